// File: rtl/nibble_serial_tx.sv
// -----------------------------------------------------------------------------
// nibble_serial_tx
//
// Framed serial transmitter. A parallel word captured from the 4-bit register
// stage is sent on a single line as a start bit (0), DATA_W data bits LSB
// first, and a stop bit (1). Each bit is held for CLKS_PER_BIT clock cycles.
// A frame occupies (DATA_W+2)*CLKS_PER_BIT cycles after the accepting edge.
// The cycle after the last stop-bit cycle is an IDLE cycle that carries the
// one-cycle done pulse, and a new load is accepted in that cycle.
//
// Parameters:
//   DATA_W        data bits per frame (>= 1)
//   CLKS_PER_BIT  clock cycles per serial bit (>= 1)
//
// Ports:
//   clk    in   sole clock, rising edge
//   reset  in   asynchronous active-high reset; aborts any frame at once
//   d      in   word to send, sampled only on an accepted load
//   load   in   start-of-frame request, honoured only while ready is high
//   ready  out  high when a load will be accepted this cycle (IDLE)
//   tx     out  serial line, idles high
//   done   out  one-cycle pulse in the IDLE cycle that follows a frame
//
// All outputs come straight from flops; load and d never reach an output
// combinationally.
// -----------------------------------------------------------------------------

// Protocol checks on the transmitter outputs; assertions only, no logic.
module nibble_serial_tx_chk (
  input logic clk,
  input logic reset,
  input logic tx,
  input logic ready,
  input logic done
);

  // done only ever appears in an IDLE cycle, where the line is high
  a_done_idle : assert property (@(posedge clk) disable iff (reset)
    done |-> (ready && tx));

  // whenever a load can be taken the line must be idling high
  a_ready_tx : assert property (@(posedge clk) disable iff (reset)
    ready |-> tx);

  // a frame is at least three cycles, so done can never repeat back to back
  a_done_pulse : assert property (@(posedge clk) disable iff (reset)
    done |=> !done);

endmodule

module nibble_serial_tx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] d,
  input  logic              load,
  output logic              ready,
  output logic              tx,
  output logic              done
);

  // Counter widths never drop below one bit so CLKS_PER_BIT=1 / DATA_W=1
  // still give legal vectors.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t              state_r;
  logic [DATA_W-1:0]   shift_r;
  logic [BIT_W-1:0]    bit_cnt_r;
  logic [CNT_W-1:0]    cyc_cnt_r;
  logic                tx_r;
  logic                ready_r;
  logic                done_r;

  logic                bit_end_s;
  logic [DATA_W-1:0]   shift_next_s;

  // Bit-boundary detect and the post-shift word used to pre-load tx.
  always_comb begin
    bit_end_s    = 1'b0;
    shift_next_s = shift_r >> 1'b1;
    if (cyc_cnt_r == CNT_LAST) begin
      bit_end_s = 1'b1;
    end else begin
      bit_end_s = 1'b0;
    end
  end

  // Frame sequencer. tx/ready/done are loaded on the same edge as the state
  // change so that the registered outputs line up with the state they
  // describe, with no decode delay and no path from load/d to the pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      shift_r   <= {DATA_W{1'b0}};
      bit_cnt_r <= BIT_ZERO;
      cyc_cnt_r <= CNT_ZERO;
      tx_r      <= 1'b1;
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
    end else begin
      // done is a single-cycle pulse; only the STOP exit raises it
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (load) begin
            shift_r   <= d;
            bit_cnt_r <= BIT_ZERO;
            cyc_cnt_r <= CNT_ZERO;
            state_r   <= START;
            tx_r      <= 1'b0;
            ready_r   <= 1'b0;
          end else begin
            tx_r    <= 1'b1;
            ready_r <= 1'b1;
          end
        end

        START: begin
          if (bit_end_s) begin
            cyc_cnt_r <= CNT_ZERO;
            bit_cnt_r <= BIT_ZERO;
            state_r   <= DATA;
            tx_r      <= shift_r[0];
          end else begin
            cyc_cnt_r <= cyc_cnt_r + CNT_ONE;
          end
        end

        DATA: begin
          if (bit_end_s) begin
            cyc_cnt_r <= CNT_ZERO;
            shift_r   <= shift_next_s;
            if (bit_cnt_r == BIT_LAST) begin
              state_r <= STOP;
              tx_r    <= 1'b1;
            end else begin
              bit_cnt_r <= bit_cnt_r + BIT_ONE;
              // next data bit is what lands in bit 0 after this shift
              tx_r      <= shift_next_s[0];
            end
          end else begin
            cyc_cnt_r <= cyc_cnt_r + CNT_ONE;
          end
        end

        STOP: begin
          if (bit_end_s) begin
            cyc_cnt_r <= CNT_ZERO;
            state_r   <= IDLE;
            tx_r      <= 1'b1;
            ready_r   <= 1'b1;
            done_r    <= 1'b1;
          end else begin
            cyc_cnt_r <= cyc_cnt_r + CNT_ONE;
          end
        end

        default: begin
          // unreachable encoding: fall back to a safe idle line
          state_r   <= IDLE;
          cyc_cnt_r <= CNT_ZERO;
          bit_cnt_r <= BIT_ZERO;
          tx_r      <= 1'b1;
          ready_r   <= 1'b1;
        end
      endcase
    end
  end

  assign tx    = tx_r;
  assign ready = ready_r;
  assign done  = done_r;

  nibble_serial_tx_chk u_chk (
    .clk   (clk),
    .reset (reset),
    .tx    (tx_r),
    .ready (ready_r),
    .done  (done_r)
  );

endmodule

// File: doc/nibble_serial_tx.md
# nibble_serial_tx

Framed serial transmitter that takes a parallel data word, captured by the lab's 4-bit registers, and shifts it out on one line. It sends a start bit, the data bits LSB-first, then a stop bit. Each bit lasts a programmable number of clock cycles. The block sits between the register stage and the serial link, and the lab's serial receiver is its counterpart.

## Interface
- `DATA_W`, default 4: data bits per frame; legal range ≥ 1.
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; legal range ≥ 1.
- `clk`, input, 1: sole clock; all state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `d`, input, `DATA_W`: word to transmit; sampled only when a load is accepted.
- `load`, input, 1: request to start a frame with the current `d`.
- `ready`, output, 1: high when a load will be accepted this cycle.
- `tx`, output, 1: serial line; idles high.
- `done`, output, 1: one-cycle pulse marking the end of a frame.

## Operation
- **FSM states:** IDLE, START, DATA, STOP. Reset forces IDLE.
- **Reset values:** `tx`=1, `ready`=1, `done`=0, bit counter=0, cycle counter=0, shift register=0.
- **IDLE:**
  - `tx`=1 and `ready`=1.
  - `load`=1 at a rising edge latches `d` into the shift register, clears both counters and moves to START.
- **START:**
  - `tx`=0 for `CLKS_PER_BIT` cycles, then move to DATA with bit index 0.
- **DATA:**
  - `tx`=shift register bit 0.
  - After `CLKS_PER_BIT` cycles the register shifts right by one.
  - If the bit index is `DATA_W`-1, move to STOP; otherwise increment the index.
- **STOP:**
  - `tx`=1 for `CLKS_PER_BIT` cycles, then move to IDLE and assert `done` for exactly one cycle.
- **Cycle counter:** counts 0..`CLKS_PER_BIT`-1 and wraps to 0 at each bit boundary. Width is clog2(`CLKS_PER_BIT`), minimum 1.
- **Bit counter:** counts 0..`DATA_W`-1. Width is clog2(`DATA_W`), minimum 1.
- **`ready`:** low in START, DATA and STOP.
  - A `load` outside IDLE is ignored, not queued.
  - Changes on `d` during a frame have no effect on the frame in flight.
- **Back-to-back frames:** a `load` in the cycle `done` is high (state IDLE) is accepted normally. The next START begins on the following cycle, with no extra idle bit beyond STOP.
- **`CLKS_PER_BIT`=1:** every bit lasts exactly one cycle. The counter never wraps ambiguously.
- **Outputs:** `tx`, `ready` and `done` are registered or decoded from registered state only. There are no combinational paths from `load` or `d` to any output.
- **Reset mid-frame:** the frame is aborted immediately, without waiting for a clock. `tx` returns to 1 at once and no `done` pulse is produced for the aborted frame.

## Timing
- **Load acceptance:** `load`=1 with `ready`=1 at edge T.
- **Frame bit periods, relative to edge T (C = `CLKS_PER_BIT`):**
  - Cycles T+1 .. T+C: `tx`=0 (start bit).
  - Cycles T+1+(i+1)·C .. T+(i+2)·C: `tx`=`d[i]`, for i = 0..`DATA_W`-1.
  - Last C cycles before frame end: `tx`=1 (stop bit).
- **`ready`:** low from T+1 through the last stop-bit cycle.
- **End of frame:** at edge T+(`DATA_W`+2)·C, `ready` returns to 1 and `done`=1 for that one cycle.
- **Frame length:** (`DATA_W`+2)·C cycles. With defaults this is 24 cycles.
- **Load latency:** one cycle from the accepting edge to the first start-bit cycle.
- **Reset edges:** `reset` assertion acts asynchronously. Deassertion is synchronous to the next edge; the first load can be accepted on the first edge after deassertion.

## Test plan
- **Reset state:** assert `reset` for 3 cycles -> `tx`=1, `ready`=1, `done`=0 throughout. Deassert -> outputs unchanged while `load`=0.
- **Single frame:** defaults, `d`=4'b1010, `load` pulsed 1 cycle.
  - `tx` follows 0×4, 0×4, 1×4, 0×4, 1×4, 1×4.
  - `ready` is low for 24 cycles, then `done` pulses once.
- **Load while busy:** during a frame, pulse `load` with `d`=4'hF mid-DATA and change `d`.
  - Frame bits are unchanged.
  - No second frame starts, and exactly one `done` pulse occurs.
- **Back-to-back:** hold `load`=1 with `d`=4'h3, then `d`=4'hC on the `done` cycle.
  - Two contiguous 24-cycle frames, with data 1,1,0,0 then 0,0,1,1.
  - No idle-high gap beyond the stop bit.
- **Async reset mid-frame:** assert `reset` between clock edges during DATA.
  - `tx`=1 and `ready`=1 before the next edge, with no `done` pulse.
  - A subsequent frame with `d`=4'h5 is transmitted correctly.
- **Edge parameters:** `CLKS_PER_BIT`=1, `DATA_W`=8, `d`=8'hA5 -> 10-cycle frame with `tx` = 0,1,0,1,0,0,1,0,1,1.
